// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared helpers for the pipelined adder/subtractor.
//   chunk_w      - per-stage chunk width (WIDTH / STAGES)
//   width_ok     - configuration legality, evaluated at elaboration by the top
//   signed_max/  - two's-complement limits, only used when PIPE_ADDER_SAT_EN
//   signed_min     is defined (results are LIMIT_W wide; callers slice them)
package pipe_adder_pkg;

  localparam int unsigned LIMIT_W = 256;

  function automatic int unsigned chunk_w(input int unsigned width,
                                          input int unsigned stages);
    return width / stages;
  endfunction

  function automatic bit width_ok(input int unsigned width,
                                  input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  function automatic logic [LIMIT_W-1:0] signed_max(input int unsigned width);
    logic [LIMIT_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LIMIT_W; i++) begin
      if (i + 1 < width) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [LIMIT_W-1:0] signed_min(input int unsigned width);
    logic [LIMIT_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LIMIT_W; i++) begin
      if (i + 1 == width) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_adder_chunk.sv
// adder_chunk: purely combinational CW-bit ripple-carry adder built from an
// unrolled full-adder chain.
//   a, b  - chunk operands
//   ci    - carry into bit 0
//   s     - chunk sum
//   co    - carry out of bit CW-1
//   c_msb - carry into bit CW-1 (used for signed overflow in the top chunk)
module adder_chunk #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          c_msb
);

  logic [CW:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CW; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[CW];
  assign c_msb = c[CW-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder/subtractor, one chunk of
// WIDTH/STAGES bits per stage, elastic valid/ready on both sides.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - operand handshake
//   A, B, Cin, Sub        - operands; Sub=1 computes A-B-Cin
//   out_valid / out_ready - result handshake
//   Sum, Cout, Ovf        - result, carry (not-borrow), signed overflow
// Optional macro PIPE_ADDER_SAT_EN: clamp Sum to the signed limit on overflow
// in the final stage (Cout/Ovf still report the unclamped result).
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned CW = chunk_w(WIDTH, STAGES);

  if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  // Source view of each stage: stage 0 sees the ports, stage k sees the
  // registers of stage k-1. B is stored already conditioned (inverted on Sub).
  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             c_src [STAGES];
  logic             v_src [STAGES];
  logic             ready [STAGES+1];

  assign a_src[0]      = A;
  assign b_src[0]      = Sub ? ~B : B;
  assign s_src[0]      = '0;
  assign c_src[0]      = Cin ^ Sub;
  assign v_src[0]      = in_valid;
  assign ready[STAGES] = out_ready;
  assign in_ready      = ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0]    s_chunk;
    logic             co;
    logic             c_msb;
    logic             v_q;
    logic [WIDTH-1:0] s_new;

    adder_chunk #(.CW(CW)) u_chunk (
      .a     (a_src[k][k*CW +: CW]),
      .b     (b_src[k][k*CW +: CW]),
      .ci    (c_src[k]),
      .s     (s_chunk),
      .co    (co),
      .c_msb (c_msb)
    );

    always_comb begin
      s_new               = s_src[k];
      s_new[k*CW +: CW]   = s_chunk;
    end

    // An empty stage always accepts, so bubbles collapse under a stall.
    assign ready[k] = !v_q || ready[k+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) v_q <= 1'b0;
      else if (ready[k]) v_q <= v_src[k];
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             unused_c_msb;

      assign unused_c_msb = c_msb;

      // Data only moves with a valid token so idle inputs never leak through.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
        end else if (ready[k] && v_src[k]) begin
          a_q <= a_src[k];
          b_q <= b_src[k];
          s_q <= s_new;
          c_q <= co;
        end
      end

      assign a_src[k+1] = a_q;
      assign b_src[k+1] = b_q;
      assign s_src[k+1] = s_q;
      assign c_src[k+1] = c_q;
      assign v_src[k+1] = v_q;
    end else begin : g_last
      logic [WIDTH-1:0] s_fin;
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             ovf_q;

`ifdef PIPE_ADDER_SAT_EN
      localparam logic [LIMIT_W-1:0] SMAX_FULL = signed_max(WIDTH);
      localparam logic [LIMIT_W-1:0] SMIN_FULL = signed_min(WIDTH);
`endif

      always_comb begin
        s_fin = s_new;
`ifdef PIPE_ADDER_SAT_EN
        // Overflow direction follows A's sign for both add and subtract.
        if (c_msb ^ co) begin
          s_fin = a_src[k][WIDTH-1] ? SMIN_FULL[WIDTH-1:0] : SMAX_FULL[WIDTH-1:0];
        end
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q   <= '0;
          c_q   <= 1'b0;
          ovf_q <= 1'b0;
        end else if (ready[k] && v_src[k]) begin
          s_q   <= s_fin;
          c_q   <= co;
          ovf_q <= c_msb ^ co;
        end
      end

      assign out_valid = v_q;
      assign Sum       = s_q;
      assign Cout      = c_q;
      assign Ovf       = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: exact integer arithmetic on the operands as numbers.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    longint ua, ub, sa, sb, ci, ur, sr, lim;
    res_t   r;
    lim = longint'(1) << W;
    ua  = longint'({{(64-W){1'b0}}, a});
    ub  = longint'({{(64-W){1'b0}}, b});
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ci  = cin ? 1 : 0;
    if (sub) begin
      ur     = ua - ub - ci;
      sr     = sa - sb - ci;
      r.cout = (ur >= 0);
    end else begin
      ur     = ua + ub + ci;
      sr     = sa + sb + ci;
      r.cout = (ur >= lim);
    end
    r.sum = ur[W-1:0];
    r.ovf = (sr > (lim / 2) - 1) || (sr < -(lim / 2));
`ifdef PIPE_ADDER_SAT_EN
    if (r.ovf) r.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor / scoreboard: samples between edges, after drivers have settled.
  logic         hold = 1'b0;
  logic [W+2:0] held;
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) check("stall_stable", {out_valid, Sum, Cout, Ovf}, held);
        hold = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: got Sum=0x%0h with no expected result pending", Sum);
          end else begin
            e = exp_q.pop_front();
            check("result", {Sum, Cout, Ovf}, e);
          end
        end else if (out_valid) begin
          hold = 1'b1;
          held = {out_valid, Sum, Cout, Ovf};
        end
      end
    end
  end

  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, output int waited);
    waited = 0;
    @(negedge clk);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    forever begin
      #1;
      if (in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        @(posedge clk);
        break;
      end
      waited++;
      if (waited > 200) begin
        check("push_timeout", 64'(waited), 64'd0);
        break;
      end
      @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Cin = 1'($urandom); Sub = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    rdy_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int lat;
    int stale;

    // Reset state
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum", 64'(Sum), 64'd0);
    check("reset_cout_ovf", 64'({Cout, Ovf}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Latency on an empty pipeline
    rdy_mode = 0;
    push_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, w);
    check("out_valid_early", 64'(out_valid), 64'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(S - 1));

    // Directed boundary operations
    push_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, w);
    push_op(32'h5, 32'h7, 1'b0, 1'b1, w);
    push_op(32'h7, 32'h5, 1'b1, 1'b1, w);
    push_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, w);
    push_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, w);
    push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, w);
    push_op(32'h0, 32'h0, 1'b1, 1'b1, w);
    drain();

    // Random traffic with random back-pressure and idle gaps
    rdy_mode = 1;
    for (int i = 0; i < 100; i++) begin
      push_op(pick(), pick(), 1'($urandom), 1'($urandom), w);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    // Fill with the output stalled, then stream through
    rdy_mode = 2;
    @(negedge clk);
    for (int i = 0; i < S; i++) begin
      push_op($urandom, $urandom, 1'($urandom), 1'($urandom), w);
      check("fill_accept_wait", 64'(w), 64'd0);
    end
    @(negedge clk);
    #1;
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    repeat (2) @(negedge clk);
    rdy_mode = 0;
    for (int i = 0; i < S; i++) begin
      push_op($urandom, $urandom, 1'($urandom), 1'($urandom), w);
      check("stream_accept_wait", 64'(w), 64'd0);
    end
    drain();

    // Reset with operations in flight
    rdy_mode = 2;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_op($urandom, $urandom, 1'($urandom), 1'($urandom), w);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_sum", 64'(Sum), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    rdy_mode = 0;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("no_stale_result", 64'(stale), 64'd0);

    // Traffic still works after the mid-flight reset
    push_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, w);
    push_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, w);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready flow control on both sides. Operands of WIDTH bits are split into STAGES equal chunks. Each chunk is added in its own pipeline stage, and its carry is registered into the next stage. This sustains one operation per clock at any width. It is the datapath-grade replacement for the fixed 4-bit combinational adder, for use where wide sums must close timing.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages, 1..WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
- clk  in  1  the block's single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in (add) / borrow-in (subtract).
- Sub  in  1  0 = A+B+Cin; 1 = A-B-Cin.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- Sum  out  WIDTH  result.
- Cout  out  1  carry-out (add) / not-borrow (subtract).
- Ovf  out  1  two's-complement signed overflow.

## Operation
- Transfer on the input side when in_valid && in_ready at a rising edge. Transfer on the output side when out_valid && out_ready.
- Subtract is implemented as A + ~B + ~Cin, so A-B-Cin with effective carry-in = Cin ^ Sub.
- Stage k (0..STAGES-1):
  - Adds chunk k of A and of the conditioned B, with the carry registered from stage k-1 (stage 0 uses the effective carry-in).
  - Registers its CW-bit partial sum, its carry-out, a valid bit v[k], and the still-unprocessed upper chunks of A and B.
  - Registers all lower result chunks already computed.
- Per-stage elastic flow control:
  - ready[STAGES] = out_ready.
  - ready[k] = !v[k] || ready[k+1].
  - in_ready = ready[0].
  - Stage k loads from stage k-1 when ready[k]. Otherwise it holds all its contents.
- Output register = stage STAGES-1.
  - Sum = assembled chunks.
  - Cout = final-stage carry.
  - Ovf = (carry into MSB) ^ Cout.
- Output values are held stable while out_valid && !out_ready.
- Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Arithmetic wraps modulo 2^WIDTH (unless the saturation macro below is defined). Cout and Ovf are always reported from the unsaturated result.

## Timing
- Reset (rst_n low, asynchronous):
  - all v[k] = 0, out_valid = 0, Sum = 0, Cout = 0, Ovf = 0.
  - in_ready = 1 from the first cycle after deassertion.
- Latency: an operand accepted at edge E gives out_valid = 1 in the cycle following edge E+STAGES-1. With STAGES=1 this is the cycle right after E.
- Throughput: 1 result per cycle while out_ready = 1.
- in_ready depends combinationally on out_ready (registered ready path not required).
- Full pipeline with out_ready = 0: in_ready = 0; no data is overwritten or lost.
- Simultaneous output pop and input push on a full pipeline: both transfers occur in the same cycle; the pipeline stays full.
- Reset asserted mid-operation: all in-flight operations are discarded; no partial result is emitted after reset.
- When valid is low, A/B/Cin/Sub are don't-care and must not change any visible output.

## Configuration
- PIPE_ADDER_SAT_EN defined:
  - On Ovf with Sub=0 or Sub=1, Sum is clamped to the signed limit: 0111…1 if A's sign bit is 0, 1000…0 otherwise.
  - Saturation is applied in the final stage; latency is unchanged.
- PIPE_ADDER_SAT_EN undefined: Sum wraps; no clamp logic is present.

## Structure
- Package pipe_adder_pkg holds:
  - function chunk_w(WIDTH, STAGES).
  - signed max/min constant functions, used under PIPE_ADDER_SAT_EN.
  - an elaboration-time check that WIDTH % STAGES == 0.
- One combinational sub-module: adder_chunk (parameter CW; ports a, b, ci → s, co, c_msb). It is an unrolled full-adder chain and is instantiated once per stage via generate.

## Test plan
- WIDTH=32, STAGES=4, out_ready=1: A=0xFFFF_FFFF, B=1, Cin=0, Sub=0 → 4 cycles later Sum=0, Cout=1, Ovf=0.
- A=0x7FFF_FFFF, B=1, Sub=0 → Ovf=1, Sum=0x8000_0000 without the macro, 0x7FFF_FFFF with PIPE_ADDER_SAT_EN.
- A=5, B=7, Sub=1, Cin=0 → Sum=0xFFFF_FFFE, Cout=0, Ovf=0; A=7, B=5, Cin=1 → Sum=1, Cout=1.
- Back-to-back 100 random operations, out_ready randomly toggled → every result matches the reference model in order; none are dropped or duplicated; outputs stay stable while stalled.
- Fill the pipeline with out_ready=0 → in_ready=0 after 4 accepts. Then out_ready=1 with in_valid=1 → one push and one pop per cycle.
- Assert rst_n low with 3 operations in flight → out_valid=0 immediately, Sum=0, in_ready=1 after release, and no stale result appears.
